lsu_stage: RTL and testbench

//  Load/store stage between EXU and WB. Takes one instruction per valid/ready handshake, runs at most one data-memory

---
 rtl/lsu_stage.sv | 258 +++++++++++++++++++++++++
 tb/tb_lsu_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Load/store stage between EXU and WB.
// Accepts one instruction per exu_valid/lsu_ready handshake. Non-memory
// instructions and misaligned accesses load the WB output register directly.
// Aligned loads and stores go through a single data-memory transaction
// (REQ -> WAIT). Load data is aligned and extended before it reaches WB.
module lsu_stage #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,             // asynchronous, active-low

  // EXU side
  input  logic              exu_valid,
  output logic              lsu_ready,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [INST_W-1:0] ex_inst,
  input  logic [XLEN-1:0]   ex_alures,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic              ex_memrd,
  input  logic              ex_memwr,
  input  logic [2:0]        ex_memop,
  input  logic [1:0]        ex_wdata_src,
  input  logic              ex_regwr,

  // WB side
  output logic              lsu_valid,
  input  logic              wb_ready,
  output logic [XLEN-1:0]   wb_pc,
  output logic [INST_W-1:0] wb_inst,
  output logic [XLEN-1:0]   wb_alures,
  output logic [XLEN-1:0]   wb_memout,
  output logic [1:0]        wb_wdata_src,
  output logic              wb_regwr,
  output logic              lsu_misalign,

  // Data-memory bus
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [XLEN-1:0]   dmem_addr,
  output logic              dmem_wen,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // An access is misaligned when the byte offset is not a multiple of its size.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic m;
    case (size)
      2'b00:   m = 1'b0;
      2'b01:   m = off[0];
      2'b10:   m = |off[1:0];
      default: m = |off;
    endcase
    return m;
  endfunction

  // Sign- or zero-extend the low bytes of an already right-aligned load word.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [2:0]      op);
    logic [XLEN-1:0] r;
    case (op)
      3'b000:  r = {{(XLEN-8){raw[7]}},   raw[7:0]};
      3'b001:  r = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b010:  r = {{(XLEN-32){raw[31]}}, raw[31:0]};
      3'b100:  r = {{(XLEN-8){1'b0}},     raw[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}},    raw[15:0]};
      3'b110:  r = {{(XLEN-32){1'b0}},    raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;

  // Instruction held for the duration of a bus transaction
  logic [XLEN-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   rs2_q;
  logic [2:0]        memop_q;
  logic [1:0]        wdata_src_q;
  logic              regwr_q;
  logic              store_q;

  // WB output register
  logic              lsu_valid_q,  lsu_valid_d;
  logic [XLEN-1:0]   wb_pc_q,      wb_pc_d;
  logic [INST_W-1:0] wb_inst_q,    wb_inst_d;
  logic [XLEN-1:0]   wb_alures_q,  wb_alures_d;
  logic [XLEN-1:0]   wb_memout_q,  wb_memout_d;
  logic [1:0]        wb_src_q,     wb_src_d;
  logic              wb_regwr_q,   wb_regwr_d;
  logic              misalign_q,   misalign_d;

  // ---------------------------------------------------------------------------
  // Handshake and event decode
  // ---------------------------------------------------------------------------
  logic ex_is_mem;
  logic ex_mis;
  logic accept;
  logic capture;
  logic rsp_load;
  logic direct_load;
  logic load_out;

  assign lsu_ready   = (state_q == ST_IDLE) & (~lsu_valid_q | wb_ready);
  assign accept      = exu_valid & lsu_ready;
  assign ex_is_mem   = ex_memrd | ex_memwr;
  assign ex_mis      = misaligned(ex_alures[2:0], ex_memop[1:0]);
  assign capture     = accept & ex_is_mem & ~ex_mis;
  // Responses only count while a transaction is actually outstanding.
  assign rsp_load    = (state_q == ST_WAIT) & dmem_rsp_valid;
  assign direct_load = accept & (~ex_is_mem | ex_mis);
  assign load_out    = rsp_load | direct_load;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // Next-state logic for the single-outstanding bus transaction.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (capture)        state_d = ST_REQ;
      ST_REQ:  if (dmem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (dmem_rsp_valid) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Latch the memory instruction on accept.
  always_ff @(posedge clk) begin
    // NOTE: these are pure datapath holding registers, qualified by the FSM,
    // so they carry no reset; nothing observes them before the first capture.
    if (capture) begin
      pc_q        <= ex_pc;
      inst_q      <= ex_inst;
      addr_q      <= ex_alures;
      rs2_q       <= ex_rs2;
      memop_q     <= ex_memop;
      wdata_src_q <= ex_wdata_src;
      regwr_q     <= ex_regwr;
      store_q     <= ex_memwr;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus request
  // ---------------------------------------------------------------------------
  logic [7:0]      size_mask;
  logic [5:0]      byte_shift;
  logic [XLEN-1:0] rdata_aligned;

  assign byte_shift = {addr_q[2:0], 3'b000};

  // Byte-enable pattern for the access size, before shifting into lane.
  always_comb begin
    size_mask = 8'h00;
    case (memop_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign dmem_req_valid = (state_q == ST_REQ);
  assign dmem_addr      = {addr_q[XLEN-1:3], 3'b000};
  assign dmem_wen       = store_q;
  assign dmem_wdata     = rs2_q << byte_shift;
  assign dmem_wmask     = size_mask << addr_q[2:0];
  assign rdata_aligned  = dmem_rdata >> byte_shift;

  // ---------------------------------------------------------------------------
  // WB output register
  // ---------------------------------------------------------------------------

  // Select the source of the next WB result: bus response or EXU directly.
  always_comb begin
    wb_pc_d     = ex_pc;
    wb_inst_d   = ex_inst;
    wb_alures_d = ex_alures;
    wb_memout_d = '0;
    wb_src_d    = ex_wdata_src;
    wb_regwr_d  = ex_regwr & ~(ex_is_mem & ex_mis);
    misalign_d  = ex_is_mem & ex_mis;
    if (rsp_load) begin
      wb_pc_d     = pc_q;
      wb_inst_d   = inst_q;
      wb_alures_d = addr_q;
      wb_memout_d = store_q ? '0 : load_extend(rdata_aligned, memop_q);
      wb_src_d    = wdata_src_q;
      wb_regwr_d  = regwr_q;
      misalign_d  = 1'b0;
    end
  end

  assign lsu_valid_d = load_out | (lsu_valid_q & ~wb_ready);

  // Output register: loads a new result, otherwise holds for WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lsu_valid_q <= 1'b0;
      wb_pc_q     <= '0;
      wb_inst_q   <= '0;
      wb_alures_q <= '0;
      wb_memout_q <= '0;
      wb_src_q    <= '0;
      wb_regwr_q  <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      lsu_valid_q <= lsu_valid_d;
      if (load_out) begin
        wb_pc_q     <= wb_pc_d;
        wb_inst_q   <= wb_inst_d;
        wb_alures_q <= wb_alures_d;
        wb_memout_q <= wb_memout_d;
        wb_src_q    <= wb_src_d;
        wb_regwr_q  <= wb_regwr_d;
        misalign_q  <= misalign_d;
      end
    end
  end

  assign lsu_valid    = lsu_valid_q;
  assign wb_pc        = wb_pc_q;
  assign wb_inst      = wb_inst_q;
  assign wb_alures    = wb_alures_q;
  assign wb_memout    = wb_memout_q;
  assign wb_wdata_src = wb_src_q;
  assign wb_regwr     = wb_regwr_q;
  assign lsu_misalign = misalign_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, lsu_ready;
  logic [63:0] ex_pc, ex_alures, ex_rs2;
  logic [31:0] ex_inst;
  logic        ex_memrd, ex_memwr, ex_regwr;
  logic [2:0]  ex_memop;
  logic [1:0]  ex_wdata_src;
  logic        lsu_valid, wb_ready;
  logic [63:0] wb_pc, wb_alures, wb_memout;
  logic [31:0] wb_inst;
  logic [1:0]  wb_wdata_src;
  logic        wb_regwr, lsu_misalign;
  logic        dmem_req_valid, dmem_req_ready, dmem_wen, dmem_rsp_valid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wmask;

  always #5 clk = ~clk;

  lsu_stage dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .lsu_ready(lsu_ready),
    .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_alures(ex_alures), .ex_rs2(ex_rs2),
    .ex_memrd(ex_memrd), .ex_memwr(ex_memwr), .ex_memop(ex_memop),
    .ex_wdata_src(ex_wdata_src), .ex_regwr(ex_regwr),
    .lsu_valid(lsu_valid), .wb_ready(wb_ready),
    .wb_pc(wb_pc), .wb_inst(wb_inst), .wb_alures(wb_alures), .wb_memout(wb_memout),
    .wb_wdata_src(wb_wdata_src), .wb_regwr(wb_regwr), .lsu_misalign(lsu_misalign),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one pending memory instruction plus the WB result slot.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] alures;
    logic [63:0] memout;
    logic [1:0]  src;
    logic        regwr;
    logic        mis;
  } wb_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic [2:0]  op;
    logic [1:0]  src;
    logic        regwr;
    logic        store;
  } ins_t;

  bit   m_valid;   // WB slot full
  wb_t  m_out;
  bit   m_busy;    // memory instruction owns the bus path
  bit   m_reqd;    // its request has been accepted, awaiting response
  ins_t m_ins;

  function automatic int nbytes(input logic [2:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic int offset(input logic [63:0] addr);
    return int'(addr % 64'd8);
  endfunction

  function automatic bit is_misaligned(input logic [63:0] addr, input logic [2:0] op);
    return (addr % 64'(nbytes(op))) != 0;
  endfunction

  // Pick n bytes starting at the access offset, then sign/zero fill.
  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [2:0] op);
    logic [63:0] v;
    int off, n;
    off = offset(addr);
    n   = nbytes(op);
    v   = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(off+k) +: 8];
    if (!op[2] && n < 8 && v[8*n-1])
      for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] exp_mask(input logic [63:0] addr, input logic [2:0] op);
    logic [7:0] m;
    int off;
    off = offset(addr);
    m = '0;
    for (int b = 0; b < 8; b++) if (b >= off && b < off + nbytes(op)) m[b] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] addr, input logic [2:0] op,
                                            input logic [63:0] rs2);
    logic [63:0] w;
    int off;
    off = offset(addr);
    w = '0;
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + nbytes(op)) w[8*b +: 8] = rs2[8*(b-off) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] mask_bits(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  // Compare the DUT with the model for the current cycle, advance the model
  // across the next rising edge, and return at the following falling edge.
  task automatic cycle();
    bit   exp_ready, n_valid, n_busy, n_reqd;
    wb_t  n_out;
    ins_t n_ins;
    #1;
    exp_ready = !m_busy && (!m_valid || wb_ready);
    check("lsu_ready", 64'(lsu_ready), 64'(exp_ready));
    check("lsu_valid", 64'(lsu_valid), 64'(m_valid));
    if (m_valid) begin
      check("wb_pc",        wb_pc,              m_out.pc);
      check("wb_inst",      64'(wb_inst),       64'(m_out.inst));
      check("wb_alures",    wb_alures,          m_out.alures);
      check("wb_memout",    wb_memout,          m_out.memout);
      check("wb_wdata_src", 64'(wb_wdata_src),  64'(m_out.src));
      check("wb_regwr",     64'(wb_regwr),      64'(m_out.regwr));
      check("lsu_misalign", 64'(lsu_misalign),  64'(m_out.mis));
    end
    check("dmem_req_valid", 64'(dmem_req_valid), 64'(m_busy && !m_reqd));
    if (m_busy && !m_reqd) begin
      check("dmem_addr",  dmem_addr,        m_ins.addr - (m_ins.addr % 64'd8));
      check("dmem_wen",   64'(dmem_wen),    64'(m_ins.store));
      check("dmem_wmask", 64'(dmem_wmask),  64'(exp_mask(m_ins.addr, m_ins.op)));
      if (m_ins.store)
        check("dmem_wdata", dmem_wdata & mask_bits(exp_mask(m_ins.addr, m_ins.op)),
              exp_wdata(m_ins.addr, m_ins.op, m_ins.rs2));
    end

    n_valid = m_valid && !wb_ready;
    n_out   = m_out;
    n_busy  = m_busy;
    n_reqd  = m_reqd;
    n_ins   = m_ins;
    if (m_busy && !m_reqd && dmem_req_ready) begin
      n_reqd = 1'b1;
    end else if (m_busy && m_reqd && dmem_rsp_valid) begin
      n_out.pc     = m_ins.pc;
      n_out.inst   = m_ins.inst;
      n_out.alures = m_ins.addr;
      n_out.memout = m_ins.store ? 64'd0 : exp_load(dmem_rdata, m_ins.addr, m_ins.op);
      n_out.src    = m_ins.src;
      n_out.regwr  = m_ins.regwr;
      n_out.mis    = 1'b0;
      n_valid = 1'b1;
      n_busy  = 1'b0;
      n_reqd  = 1'b0;
    end
    if (exp_ready && exu_valid) begin
      if (!ex_memrd && !ex_memwr) begin
        n_out = '{ex_pc, ex_inst, ex_alures, 64'd0, ex_wdata_src, ex_regwr, 1'b0};
        n_valid = 1'b1;
      end else if (is_misaligned(ex_alures, ex_memop)) begin
        n_out = '{ex_pc, ex_inst, ex_alures, 64'd0, ex_wdata_src, 1'b0, 1'b1};
        n_valid = 1'b1;
      end else begin
        n_ins  = '{ex_pc, ex_inst, ex_alures, ex_rs2, ex_memop, ex_wdata_src, ex_regwr, ex_memwr};
        n_busy = 1'b1;
        n_reqd = 1'b0;
      end
    end
    @(posedge clk);
    m_valid = n_valid;
    m_out   = n_out;
    m_busy  = n_busy;
    m_reqd  = n_reqd;
    m_ins   = n_ins;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_reqd  = 1'b0;
    m_out   = '{64'd0, 32'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0};
  endtask

  task automatic set_idle();
    exu_valid      = 1'b0;
    ex_memrd       = 1'b0;
    ex_memwr       = 1'b0;
    ex_memop       = 3'd0;
    ex_regwr       = 1'b0;
    ex_wdata_src   = 2'd0;
    wb_ready       = 1'b1;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
  endtask

  // Present one memory instruction for a single cycle.
  task automatic mem_op(input bit store, input logic [2:0] op, input logic [63:0] addr,
                        input logic [63:0] rs2);
    exu_valid    = 1'b1;
    ex_memrd     = !store;
    ex_memwr     = store;
    ex_memop     = op;
    ex_alures    = addr;
    ex_rs2       = rs2;
    ex_regwr     = 1'b1;
    ex_pc        = {32'd0, $urandom};
    ex_inst      = $urandom;
    ex_wdata_src = 2'd1;
    cycle();
    exu_valid = 1'b0;
    ex_memrd  = 1'b0;
    ex_memwr  = 1'b0;
  endtask

  // Zero-wait bus: accept the request, then respond on the next cycle.
  task automatic bus_finish(input logic [63:0] rdata);
    dmem_req_ready = 1'b1;
    cycle();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = rdata;
    cycle();
    dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ex_pc = '0; ex_inst = '0; ex_alures = '0; ex_rs2 = '0; dmem_rdata = '0;
    set_idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_lsu_valid", 64'(lsu_valid), 64'd0);
    check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    check("rst_misalign",  64'(lsu_misalign), 64'd0);
    check("rst_wb_pc",     wb_pc, 64'd0);
    check("rst_wb_alures", wb_alures, 64'd0);
    check("rst_wb_memout", wb_memout, 64'd0);
    check("rst_wb_regwr",  64'(wb_regwr), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // ALU pass-through, one cycle of latency
    exu_valid = 1'b1; ex_alures = 64'h1234; ex_regwr = 1'b1; ex_pc = 64'h100; ex_inst = 32'h13;
    cycle();
    check("t1_valid",  64'(lsu_valid), 64'd1);
    check("t1_alures", wb_alures, 64'h1234);
    check("t1_ready",  64'(lsu_ready), 64'd1);
    exu_valid = 1'b0;

    // lb / lbu of byte 3 = 0x80
    mem_op(1'b0, 3'b000, 64'h8000_0003, 64'd0);
    bus_finish(64'h0000_0000_80FF_0000);
    check("t2_lb",  wb_memout, 64'hFFFF_FFFF_FFFF_FF80);
    mem_op(1'b0, 3'b100, 64'h8000_0003, 64'd0);
    bus_finish(64'h0000_0000_80FF_0000);
    check("t2_lbu", wb_memout, 64'h80);

    // sh into the top halfword
    mem_op(1'b1, 3'b001, 64'h8000_0006, 64'hBEEF);
    #1;
    check("t3_wmask", 64'(dmem_wmask), 64'hC0);
    check("t3_wdata", 64'(dmem_wdata[63:48]), 64'hBEEF);
    check("t3_addr",  dmem_addr, 64'h8000_0000);
    bus_finish($urandom);
    check("t3_valid", 64'(lsu_valid), 64'd1);
    check("t3_regwr", 64'(wb_regwr), 64'd1);
    cycle();

    // Backpressure: held result blocks the next load
    wb_ready = 1'b0;
    exu_valid = 1'b1; ex_alures = 64'hABCD;
    cycle();
    exu_valid = 1'b1; ex_memrd = 1'b1; ex_memop = 3'b011; ex_alures = 64'h1000;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_ready", 64'(lsu_ready), 64'd0);
      check("t4_req",   64'(dmem_req_valid), 64'd0);
      check("t4_hold",  wb_alures, 64'hABCD);
    end
    wb_ready = 1'b1;
    cycle();
    exu_valid = 1'b0; ex_memrd = 1'b0;
    bus_finish({$urandom, $urandom});

    // Misaligned lw
    mem_op(1'b0, 3'b010, 64'h8000_0012, 64'd0);
    check("t5_valid", 64'(lsu_valid), 64'd1);
    check("t5_mis",   64'(lsu_misalign), 64'd1);
    check("t5_regwr", 64'(wb_regwr), 64'd0);
    check("t5_req",   64'(dmem_req_valid), 64'd0);
    cycle();

    // Reset while waiting for a response; late response is ignored
    mem_op(1'b0, 3'b011, 64'h2000, 64'd0);
    dmem_req_ready = 1'b1;
    cycle();
    dmem_req_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_rst_valid", 64'(lsu_valid), 64'd0);
    check("t6_rst_req",   64'(dmem_req_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rdata = {$urandom, $urandom};
    cycle();
    dmem_rsp_valid = 1'b0;
    check("t6_valid", 64'(lsu_valid), 64'd0);
    check("t6_ready", 64'(lsu_ready), 64'd1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      int kind;
      kind         = $urandom_range(0, 2);
      exu_valid    = ($urandom_range(0, 9) < 6);
      ex_memrd     = (kind == 1);
      ex_memwr     = (kind == 2);
      ex_memop     = 3'($urandom_range(0, 6));
      ex_pc        = {$urandom, $urandom};
      ex_inst      = $urandom;
      ex_rs2       = {$urandom, $urandom};
      ex_alures    = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        ex_alures = ex_alures - (ex_alures % 64'(nbytes(ex_memop)));
      ex_wdata_src   = 2'($urandom_range(0, 3));
      ex_regwr       = 1'($urandom_range(0, 1));
      wb_ready       = ($urandom_range(0, 3) != 0);
      dmem_req_ready = 1'($urandom_range(0, 1));
      dmem_rsp_valid = m_reqd ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      dmem_rdata     = {$urandom, $urandom};
      cycle();
    end

    set_idle();
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
